// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic MIPS instructions into 32-bit words
// and writes them sequentially into instruction memory from address 0.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic              err_seen
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic                err_seen_q, err_seen_d;
  logic                last_q, last_d;

  logic [31:0]         enc_word;
  logic                legal;
  logic                accept;
  logic [CNT_W-1:0]    count_inc;

  // Encode the presented fields; unused fields are forced to zero.
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (in_mnem)
      4'd0:    enc_word = '0;
      4'd1:    enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADDU};
      4'd2:    enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUBU};
      4'd3:    enc_word = {OP_RTYPE, in_rs, 5'd0, 5'd0, 5'd0, FN_JR};
      4'd4:    enc_word = {OP_LW, in_rs, in_rt, in_imm};
      4'd5:    enc_word = {OP_SW, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {OP_LUI, 5'd0, in_rt, in_imm};
      4'd8:    enc_word = {OP_ORI, in_rs, in_rt, in_imm};
      4'd9:    enc_word = {OP_JAL, in_target};
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + CNT_W'(1);

  // Next-state and register-input logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    we_d       = 1'b0;
    done_d     = done_q;
    full_d     = full_q;
    err_d      = 1'b0;
    err_seen_d = err_seen_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (legal) begin
            wdata_d = enc_word;
            addr_d  = count_q[ADDR_W-1:0];
            last_d  = in_last;
            we_d    = 1'b1;
            state_d = S_WRITE;
          end else begin
            err_d      = 1'b1;
            err_seen_d = 1'b1;
            if (in_last) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_WRITE: begin
        count_d = count_inc;
        if (count_inc == DEPTH_C) full_d = 1'b1;
        if (last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (count_inc == DEPTH_C) begin
          state_d = S_FULL;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_seen_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      we_q       <= we_d;
      done_q     <= done_d;
      full_q     <= full_d;
      err_q      <= err_d;
      err_seen_q <= err_seen_d;
      last_q     <= last_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign done     = done_q;
  assign full     = full_q;
  assign err      = err_q;
  assign err_seen = err_seen_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the MIPS control decoder: takes symbolic instructions (mnemonic code plus register, immediate and target fields) over a valid/ready handshake.
- Assembles each into a 32-bit MIPS machine word.
- Writes the words sequentially into instruction memory, starting at address 0.
- Used by the test harness to preload programs for the single-cycle CPU, covering exactly the supported subset: addu, subu, jr, lw, sw, beq, lui, ori, jal, nop.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory.
- DEPTH, 1024, number of words that may be written; must be no greater than 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction fields are valid this cycle.
- in_ready  output  1  block can accept an instruction this cycle.
- in_mnem  input  4  mnemonic code: 0 nop, 1 addu, 2 subu, 3 jr, 4 lw, 5 sw, 6 beq, 7 lui, 8 ori, 9 jal; 10–15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate / branch offset field.
- in_target  input  26  jal target field.
- in_last  input  1  marks the final instruction of the program.
- im_we  output  1  instruction-memory write strobe.
- im_addr  output  ADDR_W  word address for the write.
- im_wdata  output  32  encoded instruction word.
- count  output  ADDR_W+1  number of words written so far.
- done  output  1  sticky; the program load has completed.
- full  output  1  sticky; DEPTH words have been written.
- err  output  1  one-cycle pulse when an illegal mnemonic is accepted.
- err_seen  output  1  sticky version of err.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All of im_we, im_addr, im_wdata, count, done, full, err and err_seen are 0.
  - Any write in progress is dropped; no im_we pulse follows a reset cycle.
- State machine states: IDLE, WRITE, DONE, FULL.
- Acceptance: an instruction is accepted on a rising edge where in_valid=1 and in_ready=1.
- in_ready is 1 only in IDLE; it is combinational from state only.
- IDLE, legal accept:
  - im_wdata is registered with the encoded word.
  - im_addr is set to count[ADDR_W-1:0].
  - The block goes to WRITE.
- IDLE, illegal accept (in_mnem ≥ 10):
  - Nothing is written.
  - err pulses 1 for the next cycle and err_seen is set.
  - The block stays in IDLE.
  - If in_last=1, it goes to DONE instead.
- WRITE (exactly one cycle):
  - im_we=1.
  - count increments on leaving WRITE.
  - Next state is DONE if the latched last flag is set. The done state has priority: when in_last=1 and count+1=DEPTH, done and full are both set and the state is DONE.
  - Otherwise next state is FULL if count+1 = DEPTH.
  - Otherwise next state is IDLE.
- im_we is 0 in every state other than WRITE.
- im_addr and im_wdata hold their values until the next accept.
- Throughput is one instruction per 2 cycles. Latency from accept edge to im_we high is 1 cycle.
- DONE and FULL are terminal: in_ready=0 and the flags hold until reset.
- Encoding rules (fields are {op, rs, rt, rd, shamt, funct} or {op, rs, rt, imm} or {op, target}):
  - nop: 32'h00000000.
  - addu: op 0, rs, rt, rd, shamt 0, funct 6'b100001.
  - subu: op 0, rs, rt, rd, shamt 0, funct 6'b100011.
  - jr: op 0, rs; rt, rd and shamt forced to 0; funct 6'b001000.
  - lw: op 6'b100011, rs, rt, imm.
  - sw: op 6'b101011, rs, rt, imm.
  - beq: op 6'b000100, rs, rt, imm.
  - lui: op 6'b001111, rs forced to 0, rt, imm.
  - ori: op 6'b001101, rs, rt, imm.
  - jal: op 6'b000011, target.
- Fields not used by a mnemonic are ignored and forced to 0 in the word.
- Input fields are don't-care when in_valid=0 or in_ready=0; they are sampled only at acceptance.

Test Plan:
- Reset, then accept addu(rs=1, rt=2, rd=3) → next cycle im_we=1, im_addr=0, im_wdata=32'h00221821; count=1 afterwards; in_ready low during WRITE.
- Accept, in sequence: ori(rs=0, rt=8, imm=16'h1234), lui(rs=5, rt=9, imm=16'hABCD), lw(rs=29, rt=4, imm=16'hFFFC), sw(rs=29, rt=4, imm=4), beq(rs=1, rt=2, imm=16'hFFFF), jr(rs=31, rt=7), jal(target=26'h0000C03), nop → words at addresses 0..7:
  - 3408_1234, 3C09_ABCD, 8FA4_FFFC, AFA4_0004, 1022_FFFF, 03E0_0008, 0C00_0C03, 0000_0000.
- Illegal mnemonic 12 between two legal ones → err pulses one cycle, no write; the second legal word lands at address 1; err_seen stays 1.
- With in_last=1 on the third instruction → done=1 after its write; in_ready=0; further in_valid is ignored; count=3.
- With DEPTH=4, stream 6 instructions → exactly 4 writes (addresses 0–3); full=1; in_ready=0.
- Assert reset during the WRITE cycle → no im_we pulse after the reset; count=0; next accept writes address 0.
